// File: rtl/rr_sel_arbiter_3_pkg.sv
// Shared types and constants for the 3-channel round-robin select arbiter.
package rr_sel_pkg;

  localparam int NUM_CH = 3;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Channel index to one-hot grant; the unused code 2'b11 maps to no grant.
  function automatic logic [NUM_CH-1:0] sel2onehot(input logic [1:0] s);
    case (s)
      SEL_CH0: sel2onehot = 3'b001;
      SEL_CH1: sel2onehot = 3'b010;
      SEL_CH2: sel2onehot = 3'b100;
      default: sel2onehot = 3'b000;
    endcase
  endfunction

  // Next channel in round-robin order, wrapping 2 -> 0.
  function automatic logic [1:0] inc_mod3(input logic [1:0] x);
    inc_mod3 = (x == SEL_CH2) ? SEL_CH0 : x + 2'd1;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_3_if.sv
// Request/grant bundle between the channel side and the arbiter.
interface rr_sel_arbiter_3_if;
  import rr_sel_pkg::*;

  logic [NUM_CH-1:0] req;
  logic              done;
  logic [1:0]        sel;
  logic [NUM_CH-1:0] gnt;
  logic              valid;
  logic              timeout;

  // Channel side: raises requests and releases, watches the grant.
  modport master (output req, done, input sel, gnt, valid, timeout);
  // Arbiter side.
  modport slave  (input req, done, output sel, gnt, valid, timeout);
endinterface

// File: rtl/rr_sel_arbiter_3_next_pick.sv
// Combinational round-robin search: first set request after last_owner.
module rr_next_pick
  import rr_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [1:0]        i_last_owner,
  output logic [1:0]        o_pick,
  output logic              o_pick_vld
);

  logic [1:0] w_c1, w_c2, w_c3;

  assign w_c1 = inc_mod3(i_last_owner);
  assign w_c2 = inc_mod3(w_c1);
  assign w_c3 = inc_mod3(w_c2);

  // Priority: last+1 beats last+2 beats last+3 (the previous owner itself).
  always_comb begin
    o_pick_vld = |i_req;
    o_pick     = w_c3;
    if (i_req[w_c2]) o_pick = w_c2;
    if (i_req[w_c1]) o_pick = w_c1;
  end

endmodule

// File: rtl/rr_sel_arbiter_3.sv
// Round-robin 3-channel arbiter driving a registered mux select.
// Optional feature macro: ARB_TIMEOUT_EN compiles in a dwell counter that
// forces release after HOLD_MAX grant cycles and pulses timeout.
module rr_sel_arbiter_3
  import rr_sel_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_sel_arbiter_3_if.slave bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 15 || (HOLD_MAX - 1) >= (1 << CNT_W)) begin : g_bad_cfg
    $error("rr_sel_arbiter_3: HOLD_MAX must be 2..15 and fit HOLD_MAX-1 in CNT_W bits");
  end

  state_t            r_state;
  logic [1:0]        r_sel;
  logic [1:0]        r_last;
  logic [NUM_CH-1:0] r_gnt;
  logic              r_valid;

  logic [1:0]        w_pick;
  logic              w_pick_vld;
  logic              w_release;
  logic              w_force;

  rr_next_pick u_pick (
    .i_req        (bus.req),
    .i_last_owner (r_last),
    .o_pick       (w_pick),
    .o_pick_vld   (w_pick_vld)
  );

  // Owner gives up on done or by dropping its own request; r_sel is the owner in GRANT.
  assign w_release = bus.done | ~bus.req[r_sel];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // A normal release in the same cycle wins over the forced one.
  assign w_force = (r_state == GRANT) && !w_release &&
                   (r_cnt == CNT_W'(HOLD_MAX - 1));

  // Dwell counter: zero on grant entry, counts every cycle spent in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_cnt <= '0;
    else if (r_state == IDLE && w_pick_vld) r_cnt <= '0;
    else if (r_state == GRANT)              r_cnt <= r_cnt + 1'b1;
  end

  // Timeout is a single-cycle pulse coinciding with the forced release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_timeout <= 1'b0;
    else        r_timeout <= w_force;
  end

  assign bus.timeout = r_timeout;
`else
  assign w_force     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Grant FSM; sel is left untouched on release so the mux holds its last input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= SEL_CH0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= SEL_CH2;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_sel   <= w_pick;
            r_gnt   <= sel2onehot(w_pick);
            r_valid <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_release || w_force) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= r_sel;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sel   = r_sel;
  assign bus.gnt   = r_gnt;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_rr_sel_arbiter_3.sv
// Directed bench for rr_sel_arbiter_3; honours ARB_TIMEOUT_EN if defined.
module tb_rr_sel_arbiter_3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  rr_sel_arbiter_3_if bus ();

  rr_sel_arbiter_3 #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] e_sel, input logic [2:0] e_gnt,
                     input logic e_vld, input logic e_to);
    n_cmp++;
    assert (bus.sel === e_sel) else begin
      n_mis++; $error("FAIL %s sel got %b exp %b", tag, bus.sel, e_sel);
    end
    n_cmp++;
    assert (bus.gnt === e_gnt) else begin
      n_mis++; $error("FAIL %s gnt got %b exp %b", tag, bus.gnt, e_gnt);
    end
    n_cmp++;
    assert (bus.valid === e_vld) else begin
      n_mis++; $error("FAIL %s valid got %b exp %b", tag, bus.valid, e_vld);
    end
    n_cmp++;
    assert (bus.timeout === e_to) else begin
      n_mis++; $error("FAIL %s timeout got %b exp %b", tag, bus.timeout, e_to);
    end
    n_cmp++;
    assert ($onehot0(bus.gnt) === 1'b1) else begin
      n_mis++; $error("FAIL %s gnt_onehot0 got %b", tag, bus.gnt);
    end
    n_cmp++;
    assert ((bus.sel !== 2'b11) === 1'b1) else begin
      n_mis++; $error("FAIL %s sel_not_11 got %b", tag, bus.sel);
    end
    n_cmp++;
    assert (bus.valid === (|bus.gnt)) else begin
      n_mis++; $error("FAIL %s valid_eq_or_gnt got %b exp %b", tag, bus.valid, |bus.gnt);
    end
  endtask

  initial begin
    bus.req  = 3'b000;
    bus.done = 1'b0;

    // Reset values
    tick(); tick();
    chk("reset", 2'b00, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 2'b00, 3'b000, 1'b0, 1'b0);

    // Full rotation with req=111, done pulsed each grant
    bus.req = 3'b111;
    tick(); chk("rr_ch0", 2'b00, 3'b001, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick(); chk("rr_rel0", 2'b00, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick(); chk("rr_ch1", 2'b01, 3'b010, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick(); chk("rr_rel1", 2'b01, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick(); chk("rr_ch2", 2'b10, 3'b100, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick(); chk("rr_rel2", 2'b10, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick(); chk("rr_ch0_again", 2'b00, 3'b001, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick(); chk("rr_rel0_again", 2'b00, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 3'b000;

    // No requests: stays idle
    for (int i = 0; i < 3; i++) begin
      tick(); chk("idle_noreq", 2'b00, 3'b000, 1'b0, 1'b0);
    end

    // Single requester ch1; non-owner changes ignored; drop own req releases
    bus.req = 3'b010;
    tick(); chk("ch1_grant", 2'b01, 3'b010, 1'b1, 1'b0);
    bus.req = 3'b111;
    tick(); chk("ch1_ignore_others", 2'b01, 3'b010, 1'b1, 1'b0);
    bus.req = 3'b011;
    tick(); chk("ch1_ignore_others2", 2'b01, 3'b010, 1'b1, 1'b0);
    bus.req = 3'b001;
    tick(); chk("ch1_drop_release", 2'b01, 3'b000, 1'b0, 1'b0);
    bus.req = 3'b000;
    tick(); chk("idle_sel_hold", 2'b01, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b1;
    tick(); chk("idle_done_ignored", 2'b01, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b0;

    // Last owner ch1, req=101: ch2 comes before ch0
    bus.req = 3'b101;
    tick(); chk("rr_skip_to_ch2", 2'b10, 3'b100, 1'b1, 1'b0);
    bus.req = 3'b001;
    tick(); chk("ch2_drop_release", 2'b10, 3'b000, 1'b0, 1'b0);
    tick(); chk("ch0_after_ch2", 2'b00, 3'b001, 1'b1, 1'b0);
    bus.req = 3'b000;
    tick(); chk("ch0_drop_release", 2'b00, 3'b000, 1'b0, 1'b0);

    // ch2 holds without done
    bus.req = 3'b100;
    tick(); chk("hold_ch2_grant", 2'b10, 3'b100, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick(); chk("hold_ch2_dwell", 2'b10, 3'b100, 1'b1, 1'b0);
    end
    tick(); chk("timeout_release", 2'b10, 3'b000, 1'b0, 1'b1);
    bus.req = 3'b111;
    tick(); chk("after_timeout_ch0", 2'b00, 3'b001, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick(); chk("after_timeout_rel", 2'b00, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b0;
    // done together with the timeout cycle: normal release, no pulse
    bus.req = 3'b010;
    tick(); chk("coinc_grant", 2'b01, 3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(); chk("coinc_dwell", 2'b01, 3'b010, 1'b1, 1'b0);
    end
    bus.done = 1'b1;
    tick(); chk("coinc_release", 2'b01, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b0;
`else
    for (int i = 0; i < 12; i++) begin
      tick(); chk("hold_ch2_persist", 2'b10, 3'b100, 1'b1, 1'b0);
    end
    bus.done = 1'b1;
    tick(); chk("hold_ch2_done", 2'b10, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b0;
`endif
    bus.req = 3'b000;
    tick();

    // Async reset in the middle of a ch1 grant
    bus.req = 3'b010;
    tick(); chk("pre_reset_ch1", 2'b01, 3'b010, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 2'b00, 3'b000, 1'b0, 1'b0);
    tick(); chk("reset_held", 2'b00, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.req = 3'b111;
    tick(); chk("post_reset_ch0", 2'b00, 3'b001, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick(); chk("post_reset_rel", 2'b00, 3'b000, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("final_idle", 2'b00, 3'b000, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter_3.md
RR_SEL_ARBITER_3 -- requirements
Module: rr_sel_arbiter_3

Interface
REQ-001 Parameter: HOLD_MAX, default 8. Maximum grant length in cycles when timeout is compiled in; legal range 2..15.
REQ-002 Parameter: CNT_W, default 4. Width of the dwell counter; SHALL hold HOLD_MAX-1.
REQ-003 Port: clk, input, 1 bit. Single clock; all state updates on the rising edge.
REQ-004 Port: rst_n, input, 1 bit. Asynchronous, active-low reset.
REQ-005 Port: req, input, 3 bits. Per-channel request; bit i is channel i.
REQ-006 Port: done, input, 1 bit. The current owner releases its grant.
REQ-007 Port: sel, output, 2 bits, registered. Channel select driven to the downstream 3:1 mux.
REQ-008 Port: gnt, output, 3 bits, registered. One-hot grant.
REQ-009 Port: valid, output, 1 bit, registered. High while a grant is active.
REQ-010 Port: timeout, output, 1 bit, registered. One-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 IDLE with req!=0: the arbiter SHALL pick the first set req bit in round-robin order last_owner+1, +2, +3 (mod 3), then enter GRANT.
- sel, gnt and valid SHALL update at that edge, giving 1-cycle latency from req to grant.
REQ-013 sel encoding SHALL be 2'b00 / 2'b01 / 2'b10 for channels 0 / 1 / 2; sel SHALL never equal 2'b11.
REQ-014 In GRANT, gnt SHALL equal the one-hot of sel and valid SHALL be 1.
REQ-015 GRANT SHALL release on the edge where done=1 or req[owner]=0.
- Release sets gnt=000, valid=0, last_owner=owner, and returns to IDLE.
REQ-016 After every release, IDLE SHALL last at least one cycle, so there are no back-to-back grants.
REQ-017 While idle, sel SHALL hold its last value; the mux input is don't-care when valid=0.
REQ-018 In IDLE, done SHALL be ignored; req changes on non-owner channels SHALL be ignored during GRANT.
REQ-019 If done=1 and the timeout condition occur in the same cycle, the release SHALL be treated as normal and timeout SHALL stay 0.

Reset
REQ-020 While rst_n=0, the block SHALL hold:
- state=IDLE, sel=2'b00, gnt=3'b000, valid=0, timeout=0;
- last_owner=2, so channel 0 wins first;
- dwell counter=0.
REQ-021 Reset asserted mid-GRANT SHALL drop the grant immediately (asynchronously), with no timeout pulse.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN, when defined, SHALL compile in the dwell counter.
- The counter clears on entry to GRANT and increments each GRANT cycle.
- When the counter equals HOLD_MAX-1 and there is no release, the next edge SHALL force a release and pulse timeout for one cycle.
REQ-023 Without ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied 0, and a grant SHALL persist until a REQ-015 release.

Structure
REQ-024 Package rr_sel_pkg SHALL hold:
- the state enum (IDLE, GRANT);
- NUM_CH=3;
- constants SEL_CH0/SEL_CH1/SEL_CH2.
REQ-025 A combinational sub-module rr_next_pick SHALL implement the round-robin search. Inputs are req and last_owner; outputs are pick index and pick valid.

Verification
REQ-026 Reset then req=111 held, done pulsed each grant: grants SHALL be ch0, ch1, ch2, ch0, with sel 00, 01, 10, 00 and one idle cycle between grants.
REQ-027 req=010 asserted at cycle 5: sel=01, gnt=010, valid=1 at cycle 6; req[1] dropped at cycle 9 -> valid=0 at cycle 10.
REQ-028 With ARB_TIMEOUT_EN and HOLD_MAX=8, ch2 holds req with no done: timeout=1 exactly 8 cycles after grant, gnt=000, then ch0 or ch1 is granted if requesting.
REQ-029 rst_n pulsed low mid-GRANT of ch1: outputs SHALL go to reset values within the same cycle; after release, ch0 wins with req=111.
REQ-030 In every scenario, assertions SHALL check that gnt is one-hot-or-zero, sel!=11, valid equals |gnt, and req=000 keeps the FSM in IDLE indefinitely.
